// File: rtl/req_enc_pkg.sv
// ----------------------------------------------------------------------------
// req_enc_pkg
//  Shared definitions for the request priority encoder slice.
//  Contents:
//   N_DEF    default number of request lines
//   W_DEF    default encoded index width (clog2 of N_DEF)
//   state_t  output-stage state encoding (ST_EMPTY / ST_FULL)
// ----------------------------------------------------------------------------
package req_enc_pkg;

   localparam int N_DEF = 8;
   localparam int W_DEF = 3;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } state_t;

endpackage

// File: rtl/req_priority_encoder_prio_find.sv
// ----------------------------------------------------------------------------
// prio_find
//  Combinational search for the first set bit of a vector, starting at a
//  given position and wrapping from N-1 back to 0.
//  Ports:
//   vec    in   N  candidate vector
//   start  in   W  position with highest priority
//   found  out  1  at least one bit of vec is set
//   idx    out  W  index of the winning bit (0 when nothing found)
//   mask   out  N  one-hot of the winning bit (0 when nothing found)
// ----------------------------------------------------------------------------
module prio_find
   import req_enc_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = $clog2(N)
) (
   input  logic [N-1:0] vec,
   input  logic [W-1:0] start,
   output logic         found,
   output logic [W-1:0] idx,
   output logic [N-1:0] mask
);

   logic [W-1:0] pos;

   // Walk offsets from farthest to nearest so the bit closest to start
   // is the last to overwrite idx. N is a power of two, so the W-bit add
   // wraps modulo N on its own.
   always_comb begin
      found = 1'b0;
      idx   = '0;
      pos   = '0;
      for (int i = N - 1; i >= 0; i--) begin
         pos = start + W'(i);
         if (vec[pos]) begin
            found = 1'b1;
            idx   = pos;
         end
      end
   end

   always_comb begin
      mask      = '0;
      mask[idx] = found;
   end

endmodule

// File: rtl/req_priority_encoder.sv
// ----------------------------------------------------------------------------
// req_priority_encoder
//  Collects request lines into a sticky pending register and emits one
//  binary index per grant over a valid/ready handshake.
//  Build option: define ROUND_ROBIN_EN for rotating priority (search starts
//  at rr_ptr); otherwise fixed priority with index 0 highest.
//  Ports:
//   clk        in   1  clock
//   clear      in   1  synchronous active-high reset
//   enable     in   1  1: sample req into pending; 0: ignore req, keep draining
//   req        in   N  request lines
//   out_ready  in   1  consumer takes code when valid && out_ready
//   code       out  W  granted index, stable while valid && !out_ready
//   valid      out  1  code holds a granted request
//   pending    out  N  pending register
//   overflow   out  1  sticky: a request hit a bit already pending
//
//  state    | meaning
//  ---------+---------------------------------------------------------
//  ST_EMPTY | no grant held; arbitrate pending every cycle
//  ST_FULL  | code holds a grant; re-arbitrate only when out_ready=1
// ----------------------------------------------------------------------------
module req_priority_encoder
   import req_enc_pkg::*;
#(
   parameter int N = N_DEF,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         clear,
   input  logic         enable,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic [W-1:0] code,
   output logic         valid,
   output logic [N-1:0] pending,
   output logic         overflow
);

   state_t       state_q, state_d;
   logic [W-1:0] code_q, code_d;
   logic [N-1:0] pend_q, pend_d;
   logic         ovf_q, ovf_d;

   logic         load;
   logic [N-1:0] req_en;
   logic [N-1:0] gmask;

   logic         g_found;
   logic [W-1:0] g_idx;
   logic [N-1:0] g_mask;
   logic [W-1:0] start;

`ifdef ROUND_ROBIN_EN
   logic [W-1:0] rr_q, rr_d;

   assign start = rr_q;

   always_comb begin
      rr_d = rr_q;
      if (load && g_found) begin
         rr_d = g_idx + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end
`else
   assign start = '0;
`endif

   prio_find #(
      .N (N),
      .W (W)
   ) u_find (
      .vec   (pend_q),
      .start (start),
      .found (g_found),
      .idx   (g_idx),
      .mask  (g_mask)
   );

   assign req_en = req & {N{enable}};

   // A fresh arbitration happens whenever the output slot is free or is
   // being emptied this cycle, which keeps one grant per cycle flowing.
   always_comb begin
      state_d = state_q;
      code_d  = code_q;
      gmask   = '0;
      load    = (state_q == ST_EMPTY) || out_ready;
      if (load) begin
         if (g_found) begin
            state_d = ST_FULL;
            code_d  = g_idx;
            gmask   = g_mask;
         end else begin
            state_d = ST_EMPTY;
         end
      end
   end

   // The granted bit leaves pending at load time; a same-cycle re-request
   // of that bit is ORed back in and is not counted as an overflow.
   always_comb begin
      pend_d = (pend_q & ~gmask) | req_en;
      ovf_d  = ovf_q | (|(req_en & pend_q & ~gmask));
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q <= ST_EMPTY;
         code_q  <= '0;
         pend_q  <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         code_q  <= code_d;
         pend_q  <= pend_d;
         ovf_q   <= ovf_d;
      end
   end

   assign code     = code_q;
   assign valid    = (state_q == ST_FULL);
   assign pending  = pend_q;
   assign overflow = ovf_q;

endmodule

// File: tb/tb_req_priority_encoder.sv
module tb_req_priority_encoder;

   localparam int N = 8;
   localparam int W = 3;

   logic         clk;
   logic         clear;
   logic         enable;
   logic [N-1:0] req;
   logic         out_ready;
   logic [W-1:0] code;
   logic         valid;
   logic [N-1:0] pending;
   logic         overflow;

   int errors = 0;
   int checks = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] exp_code;

   req_priority_encoder #(.N(N), .W(W)) dut (
      .clk       (clk),
      .clear     (clear),
      .enable    (enable),
      .req       (req),
      .out_ready (out_ready),
      .code      (code),
      .valid     (valid),
      .pending   (pending),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      req   = '0;
      tick();
      clear = 1'b0;
   endtask

   task automatic pop_exp();
      if (exp_q.size() == 0) begin
         exp_code = 'x;
      end else begin
         exp_code = exp_q.pop_front();
      end
   endtask

   task automatic test_reset();
      clear = 1'b1; enable = 1'b1; req = 8'hFF; out_ready = 1'b1;
      tick();
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
      checks++; if (code !== 3'd0) begin errors++; $display("FAIL reset_code got=%0d exp=0", code); end
      checks++; if (pending !== 8'h00) begin errors++; $display("FAIL reset_pending got=%h exp=00", pending); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
      clear = 1'b0; req = '0;
      tick();
   endtask

   task automatic test_burst();
      req = 8'b1010_0100; out_ready = 1'b1;
      exp_q.push_back(3'd2); exp_q.push_back(3'd5); exp_q.push_back(3'd7);
      tick();
      req = '0;
      checks++; if (pending !== 8'hA4 || valid !== 1'b0) begin
         errors++; $display("FAIL burst_latch pending=%h valid=%b exp pending=a4 valid=0", pending, valid);
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         pop_exp();
         checks++; if (valid !== 1'b1 || code !== exp_code) begin
            errors++; $display("FAIL burst_grant%0d valid=%b code=%0d exp valid=1 code=%0d", i, valid, code, exp_code);
         end
      end
      tick();
      checks++; if (valid !== 1'b0 || pending !== 8'h00) begin
         errors++; $display("FAIL burst_drained valid=%b pending=%h exp 0/00", valid, pending);
      end
   endtask

   task automatic test_hold();
      do_clear();
      req = 8'h08; out_ready = 1'b1;
      exp_q.push_back(3'd3); exp_q.push_back(3'd0);
      tick();
      req = 8'h01; out_ready = 1'b0;
      pop_exp();
      for (int i = 0; i < 5; i++) begin
         tick();
         req = '0;
         checks++; if (valid !== 1'b1 || code !== exp_code) begin
            errors++; $display("FAIL hold_cycle%0d valid=%b code=%0d exp valid=1 code=%0d", i, valid, code, exp_code);
         end
      end
      checks++; if (pending !== 8'h01) begin errors++; $display("FAIL hold_pending got=%h exp=01", pending); end
      out_ready = 1'b1;
      tick();
      pop_exp();
      checks++; if (valid !== 1'b1 || code !== exp_code) begin
         errors++; $display("FAIL hold_release valid=%b code=%0d exp valid=1 code=%0d", valid, code, exp_code);
      end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL hold_no_overflow got=%b exp=0", overflow); end
      tick();
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_empty valid=%b exp=0", valid); end
   endtask

   task automatic test_overflow();
      do_clear();
      out_ready = 1'b0; req = 8'h11;
      tick();
      req = '0;
      tick();
      checks++; if (valid !== 1'b1 || code !== 3'd0 || pending !== 8'h10 || overflow !== 1'b0) begin
         errors++; $display("FAIL ovf_setup valid=%b code=%0d pending=%h ovf=%b exp 1/0/10/0", valid, code, pending, overflow);
      end
      req = 8'h10;
      tick();
      req = '0;
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", overflow); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      checks++; if (overflow !== 1'b1 || valid !== 1'b0) begin
         errors++; $display("FAIL ovf_sticky ovf=%b valid=%b exp 1/0", overflow, valid);
      end
      do_clear();
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", overflow); end
   endtask

   task automatic test_clear_override();
      do_clear();
      out_ready = 1'b0; req = 8'hF1;
      tick();
      req = '0;
      tick();
      checks++; if (pending !== 8'hF0 || valid !== 1'b1) begin
         errors++; $display("FAIL clr_setup pending=%h valid=%b exp f0/1", pending, valid);
      end
      clear = 1'b1; req = 8'h01; out_ready = 1'b1;
      tick();
      clear = 1'b0; req = '0;
      checks++; if (valid !== 1'b0 || pending !== 8'h00 || code !== 3'd0) begin
         errors++; $display("FAIL clr_override valid=%b pending=%h code=%0d exp 0/00/0", valid, pending, code);
      end
   endtask

   task automatic test_enable();
      do_clear();
      enable = 1'b0; req = 8'hFF; out_ready = 1'b1;
      tick();
      tick();
      checks++; if (pending !== 8'h00 || valid !== 1'b0) begin
         errors++; $display("FAIL en_block pending=%h valid=%b exp 00/0", pending, valid);
      end
      enable = 1'b1; req = 8'h06;
      exp_q.push_back(3'd1); exp_q.push_back(3'd2);
      tick();
      enable = 1'b0; req = 8'hFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         pop_exp();
         checks++; if (valid !== 1'b1 || code !== exp_code) begin
            errors++; $display("FAIL en_drain%0d valid=%b code=%0d exp valid=1 code=%0d", i, valid, code, exp_code);
         end
      end
      tick();
      checks++; if (valid !== 1'b0 || pending !== 8'h00) begin
         errors++; $display("FAIL en_done valid=%b pending=%h exp 0/00", valid, pending);
      end
      enable = 1'b1; req = '0;
   endtask

   task automatic test_back_to_back();
      do_clear();
      req = 8'h81; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
`ifdef ROUND_ROBIN_EN
         exp_q.push_back((i % 2 == 0) ? 3'd0 : 3'd7);
`else
         exp_q.push_back(3'd0);
`endif
      end
      tick();
      for (int i = 0; i < 6; i++) begin
         tick();
         pop_exp();
         checks++; if (valid !== 1'b1 || code !== exp_code) begin
            errors++; $display("FAIL b2b_grant%0d valid=%b code=%0d exp valid=1 code=%0d", i, valid, code, exp_code);
         end
      end
      checks++; if (exp_q.size() != 0) begin
         errors++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size());
      end
      do_clear();
   endtask

   initial begin
      clear = 1'b1; enable = 1'b1; req = '0; out_ready = 1'b1;
      test_reset();
      test_burst();
      test_hold();
      test_overflow();
      test_clear_override();
      test_enable();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
